// File: rtl/tile_collider.sv
// tile_collider: multi-cycle box-vs-tile-map collision scan with early exit on first solid tile.
// Define TILE_COLLIDER_HIT_POS_EN to add resp_tx/resp_ty reporting the first solid tile.
module tile_collider #(
  parameter int MAP_W      = 16,
  parameter int MAP_H      = 16,
  parameter int TILE_SHIFT = 3,
  parameter int COORD_W    = 16,
  parameter int DIM_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [COORD_W-1:0]              req_x,
  input  logic [COORD_W-1:0]              req_y,
  input  logic [DIM_W-1:0]                req_w,
  input  logic [DIM_W-1:0]                req_h,
  output logic                            map_rd,
  output logic [$clog2(MAP_W*MAP_H)-1:0]  map_addr,
  input  logic                            map_data,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic                            resp_solid
`ifdef TILE_COLLIDER_HIT_POS_EN
  ,
  output logic [$clog2(MAP_W)-1:0]        resp_tx,
  output logic [$clog2(MAP_H)-1:0]        resp_ty
`endif
);
  localparam int TXW = $clog2(MAP_W);
  localparam int TYW = $clog2(MAP_H);
  localparam int CW  = COORD_W + 1;
  localparam logic [CW-1:0] XMAX = CW'((MAP_W << TILE_SHIFT) - 1);
  localparam logic [CW-1:0] YMAX = CW'((MAP_H << TILE_SHIFT) - 1);
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, RESP} state_t;
  state_t state;
  logic [COORD_W-1:0] lx, ly;
  logic [DIM_W-1:0] lw, lh;
  logic [CW-1:0] xc, yc, xe, ye;
  logic [TXW-1:0] tx0, tx1, rd_tx, sx0, sx1;
  logic [TYW-1:0] ty1, rd_ty, sy0, sy1;
  logic d_valid, d_last, rd_last, fin;
`ifdef TILE_COLLIDER_HIT_POS_EN
  logic [TXW-1:0] d_tx;
  logic [TYW-1:0] d_ty;
`endif
  always_comb begin
    xc = lx[COORD_W-1] ? '0 : CW'(lx);
    yc = ly[COORD_W-1] ? '0 : CW'(ly);
    xe = xc + CW'(lw) - CW'(1);
    ye = yc + CW'(lh) - CW'(1);
    sx0 = TXW'((xc > XMAX ? XMAX : xc) >> TILE_SHIFT);
    sx1 = TXW'((xe > XMAX ? XMAX : xe) >> TILE_SHIFT);
    sy0 = TYW'((yc > YMAX ? YMAX : yc) >> TILE_SHIFT);
    sy1 = TYW'((ye > YMAX ? YMAX : ye) >> TILE_SHIFT);
    rd_last = (rd_tx == tx1) && (rd_ty == ty1);
    fin = d_valid && (map_data || d_last);
  end
  assign map_addr  = {rd_ty, rd_tx};
  assign req_ready = rst_n && (state == IDLE);
  // Two-stage scan: the read on the bus now, and the one whose data is returning now.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      lx         <= '0;
      ly         <= '0;
      lw         <= '0;
      lh         <= '0;
      tx0        <= '0;
      tx1        <= '0;
      ty1        <= '0;
      rd_tx      <= '0;
      rd_ty      <= '0;
      d_valid    <= 1'b0;
      d_last     <= 1'b0;
      map_rd     <= 1'b0;
      resp_valid <= 1'b0;
      resp_solid <= 1'b0;
`ifdef TILE_COLLIDER_HIT_POS_EN
      d_tx       <= '0;
      d_ty       <= '0;
      resp_tx    <= '0;
      resp_ty    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lx    <= req_x;
          ly    <= req_y;
          lw    <= req_w;
          lh    <= req_h;
          state <= SETUP;
        end
        SETUP: begin
          d_valid <= 1'b0;
          if (lw == '0 || lh == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_solid <= 1'b0;
          end else begin
            tx0    <= sx0;
            tx1    <= sx1;
            ty1    <= sy1;
            rd_tx  <= sx0;
            rd_ty  <= sy0;
            map_rd <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          d_valid <= map_rd;
          d_last  <= rd_last;
`ifdef TILE_COLLIDER_HIT_POS_EN
          d_tx    <= rd_tx;
          d_ty    <= rd_ty;
`endif
          if (fin) begin
            state      <= RESP;
            map_rd     <= 1'b0;
            resp_valid <= 1'b1;
            resp_solid <= map_data;
`ifdef TILE_COLLIDER_HIT_POS_EN
            resp_tx    <= map_data ? d_tx : '0;
            resp_ty    <= map_data ? d_ty : '0;
`endif
          end else begin
            map_rd <= map_rd && !rd_last;
            if (map_rd && !rd_last) begin
              rd_tx <= (rd_tx == tx1) ? tx0 : rd_tx + 1'b1;
              rd_ty <= (rd_tx == tx1) ? rd_ty + 1'b1 : rd_ty;
            end
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_solid <= 1'b0;
`ifdef TILE_COLLIDER_HIT_POS_EN
          resp_tx    <= '0;
          resp_ty    <= '0;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
